// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory read arbiter: FSM encoding,
// default widths, port indices and the round-robin winner selection.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_LOAD   = 1'b1;

    // A lone requester always wins; on a tie the port not served last wins.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic last_grant);
        logic win;
        if (req0 && req1) begin
            win = ~last_grant;
        end else if (req1) begin
            win = PORT_LOAD;
        end else begin
            win = PORT_IFETCH;
        end
        return win;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hit/miss performance statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Count up on inc, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin read arbiter sharing one memory hierarchy between the
// instruction-fetch port (0) and the data-load port (1), with hit/miss stats.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              hit0,
    output logic              hit1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    input  logic              mem_hmbar,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    state_t              state_r;
    state_t              state_s;
    logic                gnt_r;
    logic                last_grant_r;
    logic                win_s;
    logic                grant_s;
    logic                capture_s;
    logic                finish_s;
    logic                mem_read_s;
    logic                hit_sel_s;
    logic                hit_inc_s;
    logic                miss_inc_s;
    logic                mem_read_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                done0_r;
    logic                done1_r;
    logic [DATA_W-1:0]   rdata0_r;
    logic [DATA_W-1:0]   rdata1_r;
    logic                hit0_r;
    logic                hit1_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; BUSY waits on the hierarchy with no timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = (req0 || req1) ? BUSY : IDLE;
            BUSY:    state_s = mem_ready ? DONE : BUSY;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode: per-state strobes and the next MemRead level.
    always_comb begin
        win_s     = pick_winner(req0, req1, last_grant_r);
        grant_s   = 1'b0;
        capture_s = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            IDLE:    grant_s   = req0 || req1;
            BUSY:    capture_s = mem_ready;
            DONE:    finish_s  = 1'b1;
            default: grant_s   = 1'b0;
        endcase
        mem_read_s = (state_s == BUSY);
    end

    // Grant latch, hierarchy drive, per-port read capture and done pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_r        <= PORT_IFETCH;
            last_grant_r <= PORT_LOAD;
            mem_read_r   <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            done0_r      <= 1'b0;
            done1_r      <= 1'b0;
            rdata0_r     <= {DATA_W{1'b0}};
            rdata1_r     <= {DATA_W{1'b0}};
            hit0_r       <= 1'b0;
            hit1_r       <= 1'b0;
        end else begin
            mem_read_r <= mem_read_s;
            done0_r    <= capture_s && (gnt_r == PORT_IFETCH);
            done1_r    <= capture_s && (gnt_r == PORT_LOAD);
            if (grant_s) begin
                gnt_r      <= win_s;
                mem_addr_r <= (win_s == PORT_LOAD) ? addr1 : addr0;
            end
            if (capture_s && (gnt_r == PORT_IFETCH)) begin
                rdata0_r <= mem_data;
                hit0_r   <= mem_hmbar;
            end
            if (capture_s && (gnt_r == PORT_LOAD)) begin
                rdata1_r <= mem_data;
                hit1_r   <= mem_hmbar;
            end
            if (finish_s) begin
                last_grant_r <= gnt_r;
            end
        end
    end

    // Statistics are bumped as DONE is left, from the port's captured flag.
    always_comb begin
        hit_sel_s  = (gnt_r == PORT_LOAD) ? hit1_r : hit0_r;
        hit_inc_s  = finish_s && hit_sel_s;
        miss_inc_s = finish_s && !hit_sel_s;
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (hit_inc_s),
        .count (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (miss_inc_s),
        .count (miss_cnt)
    );

    assign mem_read = mem_read_r;
    assign mem_addr = mem_addr_r;
    assign done0    = done0_r;
    assign done1    = done1_r;
    assign rdata0   = rdata0_r;
    assign rdata1   = rdata1_r;
    assign hit0     = hit0_r;
    assign hit1     = hit1_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level round-robin model.
module tb_mem_arbiter;

    localparam int AW   = 15;
    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic          done0, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic          hit0, hit1;
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          mem_hmbar;
    logic [CW-1:0] hit_cnt, miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int            m_last;
    logic [DW-1:0] m_rdata [0:1];
    logic          m_hit   [0:1];
    int            m_hits, m_misses;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          read_ok;
        logic          addr_ok;
        logic          d0;
        logic          d1;
        logic [DW-1:0] r0;
        logic [DW-1:0] r1;
        logic          h0;
        logic          h1;
        logic          rd_done;
        logic          d0a;
        logic          d1a;
    } obs_t;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .hit0(hit0), .hit1(hit1),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_data(mem_data),
        .mem_ready(mem_ready), .mem_hmbar(mem_hmbar),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    function automatic int exp_winner(input logic r0, input logic r1);
        if (r0 && r1) return (m_last == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_last = 1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_hit[0] = 1'b0; m_hit[1] = 1'b0;
        m_hits = 0; m_misses = 0;
    endtask

    task automatic model_commit(input int w, input logic [DW-1:0] d, input logic h);
        m_last = w;
        m_rdata[w] = d;
        m_hit[w] = h;
        if (h) m_hits = (m_hits < CMAX) ? m_hits + 1 : CMAX;
        else   m_misses = (m_misses < CMAX) ? m_misses + 1 : CMAX;
    endtask

    // Drives one transaction from an IDLE negedge (reqs already set) and
    // records what the DUT shows; ends at the negedge of the following IDLE.
    task automatic run_txn(input int lat, input logic [DW-1:0] d, input logic h,
                           input bit drop, input bit perturb, output obs_t o);
        o = '0;
        @(posedge clk);
        @(negedge clk);
        o.addr = mem_addr;
        o.read_ok = (mem_read === 1'b1);
        o.addr_ok = 1'b1;
        for (int i = 0; i < lat; i++) begin
            if (perturb) begin
                addr0 = AW'($urandom);
                addr1 = AW'($urandom);
            end
            @(negedge clk);
            if (mem_read !== 1'b1) o.read_ok = 1'b0;
            if (mem_addr !== o.addr) o.addr_ok = 1'b0;
        end
        mem_ready = 1'b1; mem_data = d; mem_hmbar = h;
        @(negedge clk);
        o.d0 = done0; o.d1 = done1; o.r0 = rdata0; o.r1 = rdata1;
        o.h0 = hit0; o.h1 = hit1; o.rd_done = mem_read;
        mem_ready = 1'b0; mem_data = $urandom; mem_hmbar = 1'($urandom);
        if (drop) begin
            if (done0) req0 = 1'b0;
            if (done1) req1 = 1'b0;
        end
        @(negedge clk);
        o.d0a = done0; o.d1a = done1;
    endtask

    task automatic test_reset();
        obs_t o;
        logic [DW-1:0] d;
        repeat (2) @(negedge clk);
        rst = 1'b1; req0 = 1'b1; addr0 = 15'h0055;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({mem_read, mem_addr, done0, done1, hit0, hit1} !== {1'b0, 15'h0000, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_ctrl: read=%b addr=%h done=%b%b hit=%b%b, want all zero",
                     mem_read, mem_addr, done0, done1, hit0, hit1);
        end
        n_tests++;
        if ({rdata0, rdata1, hit_cnt, miss_cnt} !== {64'h0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_data: rdata0=%h rdata1=%h hit_cnt=%0d miss_cnt=%0d, want 0",
                     rdata0, rdata1, hit_cnt, miss_cnt);
        end
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: mem_read=%b with req0 held in reset, want 0", mem_read);
        end
        req1 = 1'b1; addr0 = 15'h0010; addr1 = 15'h0200; rst = 1'b1;
        d = $urandom;
        run_txn(1, d, 1'b1, 1'b1, 1'b0, o);
        n_tests++;
        if (o.addr !== 15'h0010 || o.d0 !== 1'b1 || o.d1 !== 1'b0) begin
            n_fail++;
            $display("FAIL first_tie: mem_addr=%h done=%b%b, want 0010 done=10", o.addr, o.d0, o.d1);
        end
        n_tests++;
        if (o.r0 !== d || o.h0 !== 1'b1) begin
            n_fail++;
            $display("FAIL first_data: rdata0=%h hit0=%b, want %h 1", o.r0, o.h0, d);
        end
        model_commit(0, d, 1'b1);
    endtask

    task automatic test_round_robin();
        obs_t o;
        logic [DW-1:0] d;
        logic h;
        int w;
        req0 = 1'b1; req1 = 1'b1; addr0 = 15'h1111; addr1 = 15'h2222;
        for (int i = 0; i < 4; i++) begin
            d = $urandom; h = 1'($urandom);
            w = exp_winner(1'b1, 1'b1);
            run_txn($urandom_range(0, 3), d, h, 1'b0, 1'b0, o);
            n_tests++;
            if (o.d0 !== (w == 0) || o.d1 !== (w == 1) || o.addr !== ((w == 1) ? addr1 : addr0)) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: done=%b%b addr=%h, want port %0d", i, o.d0, o.d1, o.addr, w);
            end
            n_tests++;
            if (o.d0a !== 1'b0 || o.d1a !== 1'b0 || o.rd_done !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_pulse[%0d]: done after=%b%b read in DONE=%b, want 0", i, o.d0a, o.d1a, o.rd_done);
            end
            n_tests++;
            if (((w == 1) ? o.r1 : o.r0) !== d || ((w == 1) ? o.h1 : o.h0) !== h) begin
                n_fail++;
                $display("FAIL rr_data[%0d]: rdata=%h hit=%b, want %h %b", i,
                         (w == 1) ? o.r1 : o.r0, (w == 1) ? o.h1 : o.h0, d, h);
            end
            model_commit(w, d, h);
        end
        req0 = 1'b0; req1 = 1'b0;
        n_tests++;
        if (hit_cnt !== CW'(m_hits) || miss_cnt !== CW'(m_misses)) begin
            n_fail++;
            $display("FAIL rr_counts: hit=%0d miss=%0d, want %0d %0d", hit_cnt, miss_cnt, m_hits, m_misses);
        end
    endtask

    task automatic test_miss_wait();
        obs_t o;
        req1 = 1'b1; addr1 = AW'($urandom);
        run_txn(20, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, o);
        model_commit(1, 32'hDEADBEEF, 1'b0);
        n_tests++;
        if (o.read_ok !== 1'b1 || o.addr_ok !== 1'b1 || o.addr !== addr1) begin
            n_fail++;
            $display("FAIL miss_hold: read_ok=%b addr_ok=%b addr=%h, want 1 1 %h", o.read_ok, o.addr_ok, o.addr, addr1);
        end
        n_tests++;
        if (o.d1 !== 1'b1 || o.d0 !== 1'b0 || o.r1 !== 32'hDEADBEEF || o.h1 !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_done: done=%b%b rdata1=%h hit1=%b, want 01 deadbeef 0", o.d0, o.d1, o.r1, o.h1);
        end
        n_tests++;
        if (miss_cnt !== CW'(m_misses) || o.r0 !== m_rdata[0]) begin
            n_fail++;
            $display("FAIL miss_cnt: miss_cnt=%0d rdata0=%h, want %0d %h", miss_cnt, o.r0, m_misses, m_rdata[0]);
        end
    endtask

    task automatic test_hit_path();
        obs_t o;
        bit quiet = 1'b1;
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done0 !== 1'b0 || done1 !== 1'b0 || mem_read !== 1'b0) quiet = 1'b0;
        end
        mem_ready = 1'b0;
        n_tests++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: activity seen with mem_ready high in IDLE, want none");
        end
        req0 = 1'b1; addr0 = AW'($urandom);
        run_txn(0, 32'h12345678, 1'b1, 1'b1, 1'b0, o);
        model_commit(0, 32'h12345678, 1'b1);
        n_tests++;
        if (o.d0 !== 1'b1 || o.r0 !== 32'h12345678 || o.h0 !== 1'b1 || o.addr !== addr0) begin
            n_fail++;
            $display("FAIL hit_done: done0=%b rdata0=%h hit0=%b addr=%h, want 1 12345678 1 %h",
                     o.d0, o.r0, o.h0, o.addr, addr0);
        end
        n_tests++;
        if (hit_cnt !== CW'(m_hits) || o.r1 !== m_rdata[1] || o.h1 !== m_hit[1]) begin
            n_fail++;
            $display("FAIL hit_cnt: hit_cnt=%0d rdata1=%h, want %0d %h", hit_cnt, o.r1, m_hits, m_rdata[1]);
        end
    endtask

    task automatic test_addr_change();
        obs_t o;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        req0 = 1'b1; req1 = 1'b0; addr0 = AW'($urandom); a = addr0;
        d = $urandom;
        run_txn(5, d, 1'b0, 1'b1, 1'b1, o);
        model_commit(0, d, 1'b0);
        n_tests++;
        if (o.addr !== a || o.addr_ok !== 1'b1 || o.d0 !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_stable: addr=%h stable=%b done0=%b, want %h 1 1", o.addr, o.addr_ok, o.d0, a);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [DW-1:0] d;
        logic h;
        logic [1:0] r;
        int w;
        for (int i = 0; i < 20; i++) begin
            r = 2'($urandom_range(1, 3));
            req0 = r[0]; req1 = r[1];
            addr0 = AW'($urandom); addr1 = AW'($urandom);
            d = $urandom; h = 1'($urandom);
            w = exp_winner(r[0], r[1]);
            run_txn($urandom_range(0, 4), d, h, 1'b1, 1'b0, o);
            model_commit(w, d, h);
            n_tests++;
            if (o.d0 !== (w == 0) || o.d1 !== (w == 1) || o.addr !== ((w == 1) ? addr1 : addr0)) begin
                n_fail++;
                $display("FAIL rnd_grant[%0d]: req=%b done=%b%b addr=%h, want port %0d", i, r, o.d0, o.d1, o.addr, w);
            end
            n_tests++;
            if (o.r0 !== m_rdata[0] || o.r1 !== m_rdata[1] || o.h0 !== m_hit[0] || o.h1 !== m_hit[1]) begin
                n_fail++;
                $display("FAIL rnd_data[%0d]: r0=%h r1=%h h=%b%b, want %h %h %b%b", i, o.r0, o.r1, o.h0, o.h1,
                         m_rdata[0], m_rdata[1], m_hit[0], m_hit[1]);
            end
            n_tests++;
            if (hit_cnt !== CW'(m_hits) || miss_cnt !== CW'(m_misses)) begin
                n_fail++;
                $display("FAIL rnd_cnt[%0d]: hit=%0d miss=%0d, want %0d %0d", i, hit_cnt, miss_cnt, m_hits, m_misses);
            end
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask

    task automatic test_saturation();
        obs_t o;
        logic [DW-1:0] d;
        req0 = 1'b1; req1 = 1'b0;
        for (int i = 0; i < CMAX + 2; i++) begin
            d = $urandom;
            run_txn(0, d, 1'b1, 1'b0, 1'b0, o);
            model_commit(0, d, 1'b1);
        end
        req0 = 1'b0;
        n_tests++;
        if (hit_cnt !== CW'(m_hits) || hit_cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL sat_hit: hit_cnt=%0d, want %0d (all ones)", hit_cnt, m_hits);
        end
        n_tests++;
        if (miss_cnt !== CW'(m_misses)) begin
            n_fail++;
            $display("FAIL sat_miss: miss_cnt=%0d, want %0d", miss_cnt, m_misses);
        end
    endtask

    task automatic test_abort();
        bit quiet = 1'b1;
        req1 = 1'b1; addr1 = AW'($urandom);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (mem_read !== 1'b0 || hit_cnt !== CW'(m_hits) || miss_cnt !== CW'(m_misses)) begin
            n_fail++;
            $display("FAIL abort_now: mem_read=%b hit=%0d miss=%0d, want 0 0 0", mem_read, hit_cnt, miss_cnt);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rst = 1'b1; req1 = 1'b0;
            end
            if (done0 !== 1'b0 || done1 !== 1'b0) quiet = 1'b0;
        end
        mem_ready = 1'b0;
        n_tests++;
        if (quiet !== 1'b1 || hit_cnt !== CW'(m_hits) || miss_cnt !== CW'(m_misses)) begin
            n_fail++;
            $display("FAIL abort_done: no_done=%b hit=%0d miss=%0d, want 1 0 0", quiet, hit_cnt, miss_cnt);
        end
    endtask

    initial begin
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        mem_data = '0; mem_ready = 1'b0; mem_hmbar = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_miss_wait();
        test_hit_path();
        test_addr_change();
        test_random();
        test_saturation();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
